// File: rtl/kmer_extend_scheduler_if.sv
// rtl/kmer_extend_scheduler_if.sv - index, extender and fragment bundle for kmer_extend_scheduler
interface kmer_extend_scheduler_if #(
    parameter int MEM_LEN       = 128,
    parameter int INDICES_COUNT = 2,
    parameter int INDICE_LEN    = 5,
    parameter int FRAG_LEN      = 8,
    parameter int BASE_LEN      = 4
);
    logic                                      mem_load;
    logic [MEM_LEN-1:0]                        mem_data;
    logic                                      idx_valid;
    logic                                      idx_ready;
    logic [INDICE_LEN-1:0]                     idx_data;
    logic                                      idx_last;
    logic [MEM_LEN-1:0]                        ext_memory;
    logic [INDICES_COUNT*INDICE_LEN-1:0]       ext_indices;
    logic [INDICES_COUNT*FRAG_LEN*BASE_LEN-1:0] ext_kmers;
    logic                                      frag_valid;
    logic                                      frag_ready;
    logic [FRAG_LEN*BASE_LEN-1:0]              frag_data;
    logic                                      frag_err;
    logic                                      frag_last;
    logic                                      busy;

    modport master (
        input  mem_load, mem_data, idx_valid, idx_data, idx_last, ext_kmers, frag_ready,
        output idx_ready, ext_memory, ext_indices, frag_valid, frag_data, frag_err, frag_last, busy
    );

    modport slave (
        output mem_load, mem_data, idx_valid, idx_data, idx_last, ext_kmers, frag_ready,
        input  idx_ready, ext_memory, ext_indices, frag_valid, frag_data, frag_err, frag_last, busy
    );
endinterface

// File: rtl/kmer_extend_scheduler.sv
// rtl/kmer_extend_scheduler.sv - batches k-mer indices into extend_kmers and streams out fragments
module kmer_extend_scheduler #(
    parameter int KMER_LEN      = 4,
    parameter int FRAG_LEN      = 8,
    parameter int BASE_LEN      = 4,
    parameter int MEM_LEN       = 128,
    parameter int INDICES_COUNT = 2,
    parameter int INDICE_LEN    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    kmer_extend_scheduler_if.master   bus
);
    localparam int FRAG_W = FRAG_LEN * BASE_LEN;
    localparam int CNT_W  = $clog2(INDICES_COUNT + 1);
    // Highest start index whose whole fragment still lies inside the read memory
    localparam logic [INDICE_LEN-1:0] MAX_IDX = INDICE_LEN'(MEM_LEN / BASE_LEN - FRAG_LEN);

    // A k-mer longer than its extended fragment makes the extender meaningless
    if (KMER_LEN > FRAG_LEN) begin : g_bad_kmer_len
        $error("KMER_LEN must not exceed FRAG_LEN");
    end

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EXTEND, S_DRAIN} state_t;

    state_t                                   state_q, state_d;
    logic [MEM_LEN-1:0]                       mem_q, mem_d;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] idx_q, idx_d;
    logic [INDICES_COUNT-1:0]                 bad_q, bad_d;
    logic [INDICES_COUNT-1:0][FRAG_W-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic [CNT_W-1:0]                         n_q, n_d;
    logic [CNT_W-1:0]                         rd_q, rd_d;
    logic                                     last_q, last_d;

    logic [INDICES_COUNT-1:0][FRAG_W-1:0]     kmers;
    logic [FRAG_W-1:0]                        cur_frag;
    logic                                     cur_bad;

    assign kmers           = bus.ext_kmers;
    assign bus.ext_memory  = mem_q;
    assign bus.ext_indices = idx_q;
    assign bus.busy        = (state_q != S_IDLE);

    // Select the buffered fragment and its bad flag for the current drain slot
    always_comb begin
        cur_frag = '0;
        cur_bad  = 1'b0;
        for (int s = 0; s < INDICES_COUNT; s++) begin
            if (rd_q == CNT_W'(s)) begin
                cur_frag = buf_q[s];
                cur_bad  = bad_q[s];
            end
        end
    end

    // Next-state and output logic of the collect / extend / drain sequencer
    always_comb begin
        state_d        = state_q;
        mem_d          = mem_q;
        idx_d          = idx_q;
        bad_d          = bad_q;
        buf_d          = buf_q;
        cnt_d          = cnt_q;
        n_d            = n_q;
        rd_d           = rd_q;
        last_d         = last_q;
        bus.idx_ready  = 1'b0;
        bus.frag_valid = 1'b0;
        bus.frag_data  = '0;
        bus.frag_err   = 1'b0;
        bus.frag_last  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_load) begin
                    mem_d   = bus.mem_data;
                    idx_d   = '0;
                    bad_d   = '0;
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                bus.idx_ready = 1'b1;
                if (bus.idx_valid) begin
                    for (int s = 0; s < INDICES_COUNT; s++) begin
                        if (cnt_q == CNT_W'(s)) begin
                            idx_d[s] = bus.idx_data;
                            bad_d[s] = (bus.idx_data > MAX_IDX);
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(INDICES_COUNT) || bus.idx_last) begin
                        n_d     = cnt_d;
                        last_d  = bus.idx_last;
                        state_d = S_EXTEND;
                    end
                end
            end

            S_EXTEND: begin
                // Slots past the batch size are cleared so stale fragments never linger
                for (int s = 0; s < INDICES_COUNT; s++) begin
                    buf_d[s] = (CNT_W'(s) < n_q) ? kmers[s] : '0;
                end
                rd_d    = '0;
                state_d = S_DRAIN;
            end

            S_DRAIN: begin
                bus.frag_valid = 1'b1;
                bus.frag_data  = cur_bad ? '0 : cur_frag;
                bus.frag_err   = cur_bad;
                bus.frag_last  = last_q && (rd_q == n_q - 1'b1);
                if (bus.frag_ready) begin
                    if (rd_q == n_q - 1'b1) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        bad_d   = '0;
                        state_d = last_q ? S_IDLE : S_COLLECT;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mem_q   <= '0;
            idx_q   <= '0;
            bad_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            rd_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            rd_q    <= rd_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_kmer_extend_scheduler.sv
// tb/tb_kmer_extend_scheduler.sv - directed table-driven bench for kmer_extend_scheduler
module tb_kmer_extend_scheduler;
    localparam logic [127:0] M1 = 128'h01234567899876543210001122334455;
    localparam logic [127:0] M2 = 128'hFEDCBA98765432100123456789ABCDEF;
    localparam int NV  = 12;
    localparam int LIM = 200;

    typedef struct {
        logic [127:0] mem;
        logic [4:0]   idx;
        logic         last;
        logic [31:0]  exp_data;
        logic         exp_err;
        logic         exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt [NV];

    always #5 clk = ~clk;

    kmer_extend_scheduler_if bus ();

    kmer_extend_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural extend_kmers: base i of the read is nibble i counted from the LSB
    function automatic logic [31:0] ext_model(input logic [127:0] m, input logic [4:0] i);
        logic [127:0] s;
        s = m >> {i, 2'b00};
        return s[31:0];
    endfunction

    assign bus.ext_kmers = {ext_model(bus.ext_memory, bus.ext_indices[9:5]),
                            ext_model(bus.ext_memory, bus.ext_indices[4:0])};

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out after %0d cycles", name, LIM);
    endtask

    task automatic load_mem(input logic [127:0] m);
        int n = 0;
        while (bus.busy && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) tmo("load_wait_idle");
        bus.mem_data = m;
        bus.mem_load = 1'b1;
        @(negedge clk);
        bus.mem_load = 1'b0;
    endtask

    task automatic push(input logic [4:0] idx, input logic last);
        int n = 0;
        bus.idx_data  = idx;
        bus.idx_last  = last;
        bus.idx_valid = 1'b1;
        while (!bus.idx_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) tmo("push_wait_ready");
        @(negedge clk);
        bus.idx_valid = 1'b0;
        bus.idx_last  = 1'b0;
    endtask

    task automatic get_frag(input string name, input logic [31:0] d, input logic e, input logic l);
        int n = 0;
        while (!bus.frag_valid && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) begin
            tmo(name);
        end else begin
            chk(name, {bus.frag_data, bus.frag_err, bus.frag_last}, {d, e, l});
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{M1, 5'd1,  1'b0, 32'h12233445, 1'b0, 1'b0};
        vt[1]  = '{M1, 5'd15, 1'b1, 32'h99876543, 1'b0, 1'b1};
        vt[2]  = '{M1, 5'd0,  1'b0, 32'h22334455, 1'b0, 1'b0};
        vt[3]  = '{M1, 5'd3,  1'b0, 32'h01122334, 1'b0, 1'b0};
        vt[4]  = '{M1, 5'd7,  1'b0, 32'h21000112, 1'b0, 1'b0};
        vt[5]  = '{M1, 5'd12, 1'b0, 32'h76543210, 1'b0, 1'b0};
        vt[6]  = '{M1, 5'd24, 1'b1, 32'h01234567, 1'b0, 1'b1};
        vt[7]  = '{M1, 5'd25, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[8]  = '{M1, 5'd3,  1'b1, 32'h01122334, 1'b0, 1'b1};
        vt[9]  = '{M1, 5'd26, 1'b1, 32'h00000000, 1'b1, 1'b1};
        vt[10] = '{M2, 5'd5,  1'b0, 32'h3456789A, 1'b0, 1'b0};
        vt[11] = '{M2, 5'd20, 1'b1, 32'hBA987654, 1'b0, 1'b1};

        rst           = 1'b1;
        bus.mem_load  = 1'b0;
        bus.mem_data  = '0;
        bus.idx_valid = 1'b0;
        bus.idx_data  = '0;
        bus.idx_last  = 1'b0;
        bus.frag_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_idx_ready",   bus.idx_ready,   0);
        chk("rst_frag_valid",  bus.frag_valid,  0);
        chk("rst_frag_err",    bus.frag_err,    0);
        chk("rst_frag_last",   bus.frag_last,   0);
        chk("rst_busy",        bus.busy,        0);
        chk("rst_ext_memory",  bus.ext_memory,  0);
        chk("rst_ext_indices", bus.ext_indices, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: reads back to back with frag_ready held high
        bus.frag_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < NV; i++) begin
                    if (i == 0 || vt[i-1].last) load_mem(vt[i].mem);
                    push(vt[i].idx, vt[i].last);
                end
            end
            begin
                for (int j = 0; j < NV; j++) begin
                    get_frag($sformatf("table_frag%0d", j), vt[j].exp_data, vt[j].exp_err, vt[j].exp_last);
                end
            end
        join
        @(negedge clk);
        chk("table_idle_after", bus.busy, 0);

        // Partial batch and first-fragment latency
        bus.frag_ready = 1'b0;
        load_mem(M1);
        push(5'd12, 1'b1);
        chk("latency_extend", {bus.frag_valid, bus.busy, bus.idx_ready, bus.ext_indices},
            {1'b0, 1'b1, 1'b0, 10'd12});
        @(negedge clk);
        chk("latency_first", {bus.frag_valid, bus.frag_data, bus.frag_err, bus.frag_last},
            {1'b1, 32'h76543210, 1'b0, 1'b1});
        bus.frag_ready = 1'b1;
        @(negedge clk);
        chk("partial_idle", bus.busy, 0);

        // Back-pressure in DRAIN while the next index is waiting
        bus.frag_ready = 1'b0;
        load_mem(M1);
        fork
            begin
                push(5'd0, 1'b0);
                push(5'd3, 1'b0);
                push(5'd7, 1'b1);
            end
            begin
                int n = 0;
                while (!bus.frag_valid && n < LIM) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= LIM) tmo("stall_wait_valid");
                repeat (4) begin
                    chk("stall_hold", {bus.idx_ready, bus.frag_valid, bus.frag_data},
                        {1'b0, 1'b1, 32'h22334455});
                    @(negedge clk);
                end
                bus.frag_ready = 1'b1;
                get_frag("stall_frag0", 32'h22334455, 1'b0, 1'b0);
                get_frag("stall_frag1", 32'h01122334, 1'b0, 1'b0);
                get_frag("stall_frag2", 32'h21000112, 1'b0, 1'b1);
            end
        join

        // mem_load during COLLECT is ignored
        load_mem(M1);
        bus.mem_data = ~M1;
        bus.mem_load = 1'b1;
        @(negedge clk);
        bus.mem_load = 1'b0;
        chk("memload_ignored", bus.ext_memory, M1);
        push(5'd1, 1'b1);
        get_frag("memload_frag", 32'h12233445, 1'b0, 1'b1);

        // Reset in DRAIN, then a clean new read
        bus.frag_ready = 1'b0;
        load_mem(M1);
        push(5'd15, 1'b1);
        @(negedge clk);
        chk("rst_pre_drain", {bus.busy, bus.frag_valid, bus.frag_data}, {1'b1, 1'b1, 32'h99876543});
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_state", {bus.busy, bus.frag_valid, bus.idx_ready, bus.frag_err, bus.ext_indices}, 0);
        chk("rst_mid_memory", bus.ext_memory, 0);
        rst = 1'b0;
        bus.frag_ready = 1'b1;
        load_mem(M2);
        push(5'd20, 1'b1);
        get_frag("post_rst_frag", 32'hBA987654, 1'b0, 1'b1);
        chk("post_rst_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
